// File: rtl/star_pkg.sv
// star_pkg: shared encodings for the star/grill hide-show sequencer
package star_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE_UP = 3'd1,
        ST_IDLE_DN = 3'd2,
        ST_G_OPEN  = 3'd3,
        ST_S_MOVE  = 3'd4,
        ST_G_CLOSE = 3'd5,
        ST_STOP    = 3'd6,
        ST_FAULT   = 3'd7
    } state_t;

    typedef enum logic {
        DIR_HIDE = 1'b0,
        DIR_SHOW = 1'b1
    } dir_t;

    localparam logic [1:0] POS_UP  = 2'b00;
    localparam logic [1:0] POS_HID = 2'b01;
    localparam logic [1:0] POS_MID = 2'b10;
    localparam logic [1:0] POS_BAD = 2'b11;

    localparam logic [1:0] GRILL_CLOSED = 2'b00;
    localparam logic [1:0] GRILL_OPEN   = 2'b01;
    localparam logic [1:0] GRILL_MID    = 2'b10;
    localparam logic [1:0] GRILL_BAD    = 2'b11;

    function automatic logic is_motion(input state_t s);
        return s == ST_G_OPEN || s == ST_S_MOVE || s == ST_G_CLOSE;
    endfunction

endpackage

// File: rtl/star_motion_timer.sv
// star_motion_timer: saturating per-phase cycle counter with expiry flag
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : restart the phase (takes priority over counting)
//   i_en         : count this cycle
//   o_expired    : counter has reached TMO_CYC-1
module star_motion_timer #(
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            cnt <= '0;
        else if (i_clr)
            cnt <= '0;
        else if (i_en && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign o_expired = cnt == LAST;

endmodule

// File: rtl/star_grill_sequencer.sv
// star_grill_sequencer: hold-to-run hide/show sequencer for N stars behind one grill
//   i_clk, i_rst         : clock, async active-high reset
//   i_press / i_pull     : hide / show request, hold-to-run
//   i_grill_pos          : 00 closed, 01 open, 10 moving, 11 invalid
//   i_star_pos           : star i at [2i+1:2i], 00 up, 01 hidden, 10 moving, 11 invalid
//   o_grill_open/close   : grill motor drives
//   o_star_hide/show     : per-star drives
//   o_fault              : latched fault, cleared only by reset
//   o_state              : current state code
module star_grill_sequencer
    import star_pkg::*;
#(
    parameter int N_STAR  = 2,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 50000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_press,
    input  logic                i_pull,
    input  logic [1:0]          i_grill_pos,
    input  logic [2*N_STAR-1:0] i_star_pos,
    output logic                o_grill_open,
    output logic                o_grill_close,
    output logic [N_STAR-1:0]   o_star_hide,
    output logic [N_STAR-1:0]   o_star_show,
    output logic                o_fault,
    output logic [2:0]          o_state
);

    state_t state_q, state_d;
    dir_t   dir_q, dir_d;
    logic   all_up, all_hid, any_bad, at_tgt, at_new, cmd_ok, expired, fault_now;
    logic   grill_open;
    logic [N_STAR-1:0] hide_d, show_d;

    assign grill_open = i_grill_pos == GRILL_OPEN;

    always_comb begin
        all_up  = 1'b1;
        all_hid = 1'b1;
        any_bad = i_grill_pos == GRILL_BAD;
        for (int i = 0; i < N_STAR; i++) begin
            all_up  = all_up  & (i_star_pos[2*i +: 2] == POS_UP);
            all_hid = all_hid & (i_star_pos[2*i +: 2] == POS_HID);
            any_bad = any_bad | (i_star_pos[2*i +: 2] == POS_BAD);
        end
    end

    assign at_tgt = dir_q == DIR_HIDE ? all_hid : all_up;
    assign cmd_ok = dir_q == DIR_HIDE ? i_press & ~i_pull : i_pull & ~i_press;

    // Idle states tolerate bad sensors; the check bites once motion is requested.
    assign fault_now = state_q != ST_IDLE_UP && state_q != ST_IDLE_DN &&
                       (any_bad || (state_q == ST_S_MOVE && !grill_open) ||
                        (is_motion(state_q) && expired));

    star_motion_timer #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_tmr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (state_d != state_q),
        .i_en      (is_motion(state_q)),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_INIT;
            dir_q   <= DIR_HIDE;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        at_new  = 1'b0;
        case (state_q)
            ST_INIT:
                state_d = i_grill_pos != GRILL_CLOSED ? ST_STOP :
                          all_up ? ST_IDLE_UP : all_hid ? ST_IDLE_DN : ST_FAULT;
            ST_IDLE_UP:
                if (i_press && !i_pull) begin
                    state_d = ST_G_OPEN;
                    dir_d   = DIR_HIDE;
                end
            ST_IDLE_DN:
                if (i_pull && !i_press) begin
                    state_d = ST_G_OPEN;
                    dir_d   = DIR_SHOW;
                end
            ST_G_OPEN:
                state_d = !cmd_ok ? ST_STOP : grill_open ? ST_S_MOVE : ST_G_OPEN;
            ST_S_MOVE:
                state_d = !cmd_ok ? ST_STOP : at_tgt ? ST_G_CLOSE : ST_S_MOVE;
            ST_G_CLOSE:
                state_d = !cmd_ok ? ST_STOP :
                          i_grill_pos != GRILL_CLOSED ? ST_G_CLOSE :
                          dir_q == DIR_HIDE ? ST_IDLE_DN : ST_IDLE_UP;
            ST_STOP:
                // A lone button picks the direction; resume wherever the sensors say.
                if (i_press ^ i_pull) begin
                    dir_d   = i_press ? DIR_HIDE : DIR_SHOW;
                    at_new  = i_press ? all_hid : all_up;
                    state_d = at_new ? ST_G_CLOSE : grill_open ? ST_S_MOVE : ST_G_OPEN;
                end
            default:
                state_d = ST_FAULT;
        endcase
        if (fault_now)
            state_d = ST_FAULT;
    end

    always_comb begin
        hide_d = '0;
        show_d = '0;
        for (int i = 0; i < N_STAR; i++) begin
            hide_d[i] = state_d == ST_S_MOVE && grill_open && dir_d == DIR_HIDE &&
                        i_star_pos[2*i +: 2] != POS_HID;
            show_d[i] = state_d == ST_S_MOVE && grill_open && dir_d == DIR_SHOW &&
                        i_star_pos[2*i +: 2] != POS_UP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_grill_open  <= 1'b0;
            o_grill_close <= 1'b0;
            o_star_hide   <= '0;
            o_star_show   <= '0;
            o_fault       <= 1'b0;
        end else begin
            o_grill_open  <= state_d == ST_G_OPEN;
            o_grill_close <= state_d == ST_G_CLOSE;
            o_star_hide   <= hide_d;
            o_star_show   <= show_d;
            o_fault       <= state_d == ST_FAULT;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_star_grill_sequencer.sv
// tb_star_grill_sequencer: directed checks of the star/grill sequencer
module tb_star_grill_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       press = 1'b0;
    logic       pull = 1'b0;
    logic [1:0] grill = 2'b00;
    logic [3:0] stars = 4'b0000;
    logic       g_open, g_close, fault;
    logic [1:0] hide, show;
    logic [2:0] st;
    int         total = 0;
    int         bad = 0;

    star_grill_sequencer #(.N_STAR(2), .TMO_W(16), .TMO_CYC(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_press       (press),
        .i_pull        (pull),
        .i_grill_pos   (grill),
        .i_star_pos    (stars),
        .o_grill_open  (g_open),
        .o_grill_close (g_close),
        .o_star_hide   (hide),
        .o_star_show   (show),
        .o_fault       (fault),
        .o_state       (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("excl", {30'd0, g_open & g_close, |(hide & show)}, 32'd0);
        chk("gate", {31'd0, (|{hide, show}) & (grill != 2'b01)}, 32'd0);
    endtask

    task automatic expect_out(input string tag, input int s, input int o, input int c,
                              input int h, input int w, input int f);
        chk({tag, ".state"}, {29'd0, st}, s);
        chk({tag, ".open"}, {31'd0, g_open}, o);
        chk({tag, ".close"}, {31'd0, g_close}, c);
        chk({tag, ".hide"}, {30'd0, hide}, h);
        chk({tag, ".show"}, {30'd0, show}, w);
        chk({tag, ".fault"}, {31'd0, fault}, f);
    endtask

    task automatic do_reset(input logic [1:0] g, input logic [3:0] s);
        rst = 1'b1;
        press = 1'b0;
        pull = 1'b0;
        grill = g;
        stars = s;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        expect_out("rst0", 0, 0, 0, 0, 0, 0);

        do_reset(2'b00, 4'b0000);
        expect_out("init_up", 1, 0, 0, 0, 0, 0);
        press = 1'b1; tick();
        expect_out("h_gopen", 3, 1, 0, 0, 0, 0);
        grill = 2'b10; tick();
        expect_out("h_gmid", 3, 1, 0, 0, 0, 0);
        grill = 2'b01; tick();
        expect_out("h_smove", 4, 0, 0, 3, 0, 0);
        stars = 4'b0001; tick();
        expect_out("h_s0done", 4, 0, 0, 2, 0, 0);
        tick();
        expect_out("h_s1wait", 4, 0, 0, 2, 0, 0);
        stars = 4'b0101; tick();
        expect_out("h_gclose", 5, 0, 1, 0, 0, 0);
        grill = 2'b10; tick();
        expect_out("h_gcmid", 5, 0, 1, 0, 0, 0);
        grill = 2'b00; tick();
        expect_out("h_idle_dn", 2, 0, 0, 0, 0, 0);

        press = 1'b0; pull = 1'b1; tick();
        expect_out("s_gopen", 3, 1, 0, 0, 0, 0);
        grill = 2'b01; tick();
        expect_out("s_smove", 4, 0, 0, 0, 3, 0);
        stars = 4'b0000; tick();
        expect_out("s_gclose", 5, 0, 1, 0, 0, 0);
        grill = 2'b00; tick();
        expect_out("s_idle_up", 1, 0, 0, 0, 0, 0);
        pull = 1'b0;

        press = 1'b1; tick();
        expect_out("r_gopen", 3, 1, 0, 0, 0, 0);
        grill = 2'b10; press = 1'b0; tick();
        expect_out("r_stop", 6, 0, 0, 0, 0, 0);
        tick();
        expect_out("r_stay", 6, 0, 0, 0, 0, 0);
        pull = 1'b1; tick();
        expect_out("r_flip", 5, 0, 1, 0, 0, 0);
        grill = 2'b00; tick();
        expect_out("r_idle_up", 1, 0, 0, 0, 0, 0);
        pull = 1'b0;

        press = 1'b1; tick();
        expect_out("b_gopen", 3, 1, 0, 0, 0, 0);
        pull = 1'b1; tick();
        expect_out("b_stop", 6, 0, 0, 0, 0, 0);
        pull = 1'b0; grill = 2'b10; tick();
        expect_out("b_resume", 3, 1, 0, 0, 0, 0);
        grill = 2'b01; tick();
        expect_out("b_smove", 4, 0, 0, 3, 0, 0);
        grill = 2'b10; tick();
        expect_out("gleave", 7, 0, 0, 0, 0, 1);

        do_reset(2'b00, 4'b0000);
        press = 1'b1; tick();
        expect_out("t_gopen", 3, 1, 0, 0, 0, 0);
        grill = 2'b10;
        repeat (15) tick();
        expect_out("t_last", 3, 1, 0, 0, 0, 0);
        tick();
        expect_out("t_fault", 7, 0, 0, 0, 0, 1);
        press = 1'b0; pull = 1'b1;
        repeat (3) tick();
        expect_out("t_stuck", 7, 0, 0, 0, 0, 1);
        pull = 1'b0;

        do_reset(2'b00, 4'b0000);
        stars = 4'b1100; press = 1'b1; tick();
        expect_out("bad_gopen", 3, 1, 0, 0, 0, 0);
        tick();
        expect_out("bad_fault", 7, 0, 0, 0, 0, 1);

        do_reset(2'b00, 4'b0001);
        expect_out("init_mix", 7, 0, 0, 0, 0, 1);
        do_reset(2'b00, 4'b0101);
        expect_out("init_dn", 2, 0, 0, 0, 0, 0);

        do_reset(2'b00, 4'b0000);
        press = 1'b1; tick();
        grill = 2'b01; tick();
        expect_out("a_smove", 4, 0, 0, 3, 0, 0);
        stars = 4'b0101; tick();
        expect_out("a_gclose", 5, 0, 1, 0, 0, 0);
        #3 rst = 1'b1;
        #1 expect_out("a_async", 0, 0, 0, 0, 0, 0);
        press = 1'b0; grill = 2'b10;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        expect_out("a_stop", 6, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
